// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with write-to-read bypass,
// synchronous clear and a per-register pending scoreboard.
module regfile_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 3,
    parameter int NUM_WR     = 2,
    parameter int BYPASS     = 1,
    parameter int ZERO_REG   = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_WR-1:0]                we,
    input  logic [NUM_WR*ADDR_WIDTH-1:0]     waddr,
    input  logic [NUM_WR*DATA_WIDTH-1:0]     wdata,
    input  logic [NUM_RD*ADDR_WIDTH-1:0]     raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0]     rdata,
    output logic [NUM_RD-1:0]                rd_busy,
    input  logic                             iss_valid,
    input  logic [ADDR_WIDTH-1:0]            iss_addr,
    output logic                             wr_conflict
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0]      r_pend;
    logic                  r_conflict;

    logic [ADDR_WIDTH-1:0] w_wa [NUM_WR];
    logic [DATA_WIDTH-1:0] w_wd [NUM_WR];
    logic                  w_wen [NUM_WR];
    logic [ADDR_WIDTH-1:0] w_ra [NUM_RD];
    logic [DATA_WIDTH-1:0] w_rv [NUM_RD];
    logic                  w_collide;
    logic                  w_iss;

    // Unpack write ports; index-0 writes are dropped when r0 is hardwired.
    always_comb begin
        for (int k = 0; k < NUM_WR; k++) begin
            w_wa[k]  = waddr[k*ADDR_WIDTH +: ADDR_WIDTH];
            w_wd[k]  = wdata[k*DATA_WIDTH +: DATA_WIDTH];
            w_wen[k] = we[k] &&
                       !((ZERO_REG != 0) && (w_wa[k] == '0));
        end
        w_iss = iss_valid &&
                !((ZERO_REG != 0) && (iss_addr == '0));
    end

    // Detect two effective writes to the same register this cycle.
    always_comb begin
        w_collide = 1'b0;
        for (int i = 0; i < NUM_WR; i++) begin
            for (int j = i + 1; j < NUM_WR; j++) begin
                if (w_wen[i] && w_wen[j] && (w_wa[i] == w_wa[j]))
                    w_collide = 1'b1;
            end
        end
    end

    // Storage, scoreboard and sticky conflict; later ports override earlier.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++)
                r_mem[i] <= '0;
            r_pend     <= '0;
            r_conflict <= 1'b0;
        end else begin
            for (int k = 0; k < NUM_WR; k++) begin
                if (w_wen[k]) begin
                    r_mem[w_wa[k]]  <= w_wd[k];
                    r_pend[w_wa[k]] <= 1'b0;
                end
            end
            if (w_iss)
                r_pend[iss_addr] <= 1'b1;
            if (w_collide)
                r_conflict <= 1'b1;
        end
    end

    // Combinational reads with optional forwarding; busy is not bypassed.
    always_comb begin
        rdata   = '0;
        rd_busy = '0;
        for (int j = 0; j < NUM_RD; j++) begin
            w_ra[j] = raddr[j*ADDR_WIDTH +: ADDR_WIDTH];
            w_rv[j] = r_mem[w_ra[j]];
            if (BYPASS != 0) begin
                for (int k = 0; k < NUM_WR; k++) begin
                    if (w_wen[k] && (w_wa[k] == w_ra[j]))
                        w_rv[j] = w_wd[k];
                end
            end
            if (((ZERO_REG != 0) && (w_ra[j] == '0)) || rst)
                w_rv[j] = '0;
            rdata[j*DATA_WIDTH +: DATA_WIDTH] = w_rv[j];
            rd_busy[j] = r_pend[w_ra[j]] && !rst;
        end
    end

    assign wr_conflict = r_conflict;

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed and random checks of regfile_mp, with and without
// bypass, against a per-register behavioural model.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  we;
    logic [4:0]  wa [2];
    logic [31:0] wd [2];
    logic [4:0]  ra [3];
    logic        iss_valid;
    logic [4:0]  iss_addr;

    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic [14:0] raddr;
    logic [95:0] rdata_b, rdata_n;
    logic [2:0]  busy_b, busy_n;
    logic        conf_b, conf_n;

    assign waddr = {wa[1], wa[0]};
    assign wdata = {wd[1], wd[0]};
    assign raddr = {ra[2], ra[1], ra[0]};

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1)) dut_b (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_b), .rd_busy(busy_b),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .wr_conflict(conf_b));

    regfile_mp #(.BYPASS(0)) dut_n (
        .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata_n), .rd_busy(busy_n),
        .iss_valid(iss_valid), .iss_addr(iss_addr),
        .wr_conflict(conf_n));

    logic [31:0] m_mem [32];
    bit          m_pend [32];
    bit          m_conf;
    int          n_assert = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rdb(input int j);
        return rdata_b[j*32 +: 32];
    endfunction

    function automatic logic [31:0] rdn(input int j);
        return rdata_n[j*32 +: 32];
    endfunction

    function automatic logic [31:0] exp_rd(input bit byp, input logic [4:0] a);
        if (rst || a == 0) return 32'h0;
        if (byp) begin
            for (int k = 1; k >= 0; k--)
                if (we[k] && wa[k] == a) return wd[k];
        end
        return m_mem[a];
    endfunction

    function automatic logic exp_busy(input logic [4:0] a);
        return rst ? 1'b0 : m_pend[a];
    endfunction

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            m_mem[r] = 32'h0;
            m_pend[r] = 1'b0;
        end
        m_conf = 1'b0;
    endtask

    task automatic model_edge();
        int cnt;
        if (rst) begin
            model_reset();
            return;
        end
        for (int r = 1; r < 32; r++) begin
            cnt = 0;
            for (int k = 0; k < 2; k++)
                if (we[k] && wa[k] == r) cnt++;
            if (cnt > 1) m_conf = 1'b1;
            if (cnt > 0) begin
                m_mem[r] = (we[1] && wa[1] == r) ? wd[1] : wd[0];
                m_pend[r] = 1'b0;
            end
            if (iss_valid && iss_addr == r) m_pend[r] = 1'b1;
        end
    endtask

    task automatic settle();
        #1;
        for (int j = 0; j < 3; j++) begin
            chk($sformatf("rd_byp%0d", j), rdb(j), exp_rd(1'b1, ra[j]));
            chk($sformatf("rd_nob%0d", j), rdn(j), exp_rd(1'b0, ra[j]));
            chk($sformatf("busy_b%0d", j), {31'h0, busy_b[j]},
                {31'h0, exp_busy(ra[j])});
            chk($sformatf("busy_n%0d", j), {31'h0, busy_n[j]},
                {31'h0, exp_busy(ra[j])});
        end
        chk("conf_b", {31'h0, conf_b}, {31'h0, m_conf});
        chk("conf_n", {31'h0, conf_n}, {31'h0, m_conf});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        rst = 0; we = 2'b00; iss_valid = 0; iss_addr = 0;
        wa[0] = 0; wa[1] = 0; wd[0] = 0; wd[1] = 0;
    endtask

    initial begin
        idle();
        ra[0] = 0; ra[1] = 0; ra[2] = 0;
        rst = 1;
        @(posedge clk);
        model_reset();
        #1;

        // 1: reset clears a loaded register
        idle(); we = 2'b01; wa[0] = 5; wd[0] = 32'hDEADBEEF; ra[0] = 5;
        settle(); tick();
        idle(); rst = 1; settle(); tick();
        idle(); settle();
        chk("t1_rd", rdb(0), 32'h0);
        chk("t1_busy", {31'h0, busy_b[0]}, 32'h0);
        chk("t1_conf", {31'h0, conf_b}, 32'h0);

        // 2: no-bypass read shows old value, then the new one
        we = 2'b01; wa[0] = 7; wd[0] = 32'h12345678; ra[0] = 7;
        settle();
        chk("t2_old", rdn(0), 32'h0);
        chk("t2_fwd", rdb(0), 32'h12345678);
        tick();
        idle(); settle();
        chk("t2_new", rdn(0), 32'h12345678);

        // 3: same-register collision, highest port wins, sticky conflict
        we = 2'b11; wa[0] = 3; wa[1] = 3;
        wd[0] = 32'hAAAA0000; wd[1] = 32'h5555FFFF; ra[0] = 3;
        settle();
        chk("t3_fwd", rdb(0), 32'h5555FFFF);
        chk("t3_conf0", {31'h0, conf_b}, 32'h0);
        tick();
        idle(); settle();
        chk("t3_st", rdn(0), 32'h5555FFFF);
        chk("t3_conf1", {31'h0, conf_b}, 32'h1);
        tick(); tick(); settle();
        chk("t3_hold", {31'h0, conf_n}, 32'h1);
        rst = 1; settle(); tick();

        // 4: register zero ignores writes, collisions and issues
        idle(); we = 2'b11; wd[0] = 32'hFFFFFFFF; wd[1] = 32'hFFFFFFFF;
        ra[0] = 0;
        settle();
        chk("t4_fwd0", rdb(0), 32'h0);
        tick();
        idle(); iss_valid = 1; iss_addr = 0; settle();
        chk("t4_conf", {31'h0, conf_b}, 32'h0);
        tick();
        idle(); settle();
        chk("t4_busy", {31'h0, busy_b[0]}, 32'h0);

        // 5: scoreboard set, clear, and set-wins-over-clear
        iss_valid = 1; iss_addr = 9; ra[0] = 9; settle(); tick();
        idle(); settle();
        chk("t5_set", {31'h0, busy_b[0]}, 32'h1);
        we = 2'b01; wa[0] = 9; wd[0] = 32'h1; settle();
        chk("t5_wb", {31'h0, busy_b[0]}, 32'h1);
        tick();
        idle(); settle();
        chk("t5_clr", {31'h0, busy_b[0]}, 32'h0);
        chk("t5_rd", rdn(0), 32'h1);
        iss_valid = 1; iss_addr = 9; settle(); tick();
        we = 2'b01; wa[0] = 9; wd[0] = 32'h2; settle(); tick();
        idle(); settle();
        chk("t5_win", {31'h0, busy_b[0]}, 32'h1);

        // 6: reset alongside a write and an issue
        we = 2'b01; wa[0] = 4; wd[0] = 32'h55; settle(); tick();
        idle(); rst = 1; we = 2'b01; wa[0] = 4; wd[0] = 32'h77;
        iss_valid = 1; iss_addr = 4; ra[0] = 4;
        settle(); tick();
        idle(); settle();
        chk("t6_rd", rdn(0), 32'h0);
        chk("t6_busy", {31'h0, busy_n[0]}, 32'h0);

        // random traffic over a narrow address range to provoke collisions
        for (int c = 0; c < 400; c++) begin
            rst = ($urandom_range(0, 59) == 0);
            we = 2'($urandom);
            for (int k = 0; k < 2; k++) begin
                wa[k] = 5'($urandom_range(0, 7));
                wd[k] = $urandom;
            end
            for (int j = 0; j < 3; j++)
                ra[j] = 5'($urandom_range(0, 7));
            iss_valid = ($urandom_range(0, 2) == 0);
            iss_addr = 5'($urandom_range(0, 7));
            settle();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
